// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the LEGv8 multi-cycle control unit: states, opcodes,
// ALU function codes, mux selects, condition codes and the control word.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_ADDS, OP_SUBS, OP_LSL, OP_LSR,
    OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_EORI,
    OP_LDUR, OP_STUR, OP_B, OP_CBZ, OP_CBNZ, OP_BCOND, OP_BAD
  } op_e;

  // R-type and D-type opcodes, IR[31:21]
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_EOR  = 11'b11001010000;
  localparam logic [10:0] OPC_ADDS = 11'b10101011000;
  localparam logic [10:0] OPC_SUBS = 11'b11101011000;
  localparam logic [10:0] OPC_LSL  = 11'b11010011011;
  localparam logic [10:0] OPC_LSR  = 11'b11010011010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;

  // I-type opcodes, IR[31:22]
  localparam logic [9:0] OPC_ADDI = 10'b1001000100;
  localparam logic [9:0] OPC_SUBI = 10'b1101000100;
  localparam logic [9:0] OPC_ANDI = 10'b1001001000;
  localparam logic [9:0] OPC_ORRI = 10'b1011001000;
  localparam logic [9:0] OPC_EORI = 10'b1101001000;

  localparam logic [5:0] OPC_B     = 6'b000101;
  localparam logic [7:0] OPC_CBZ   = 8'b10110100;
  localparam logic [7:0] OPC_CBNZ  = 8'b10110101;
  localparam logic [7:0] OPC_BCOND = 8'b01010100;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_LSR = 5'b10000;
  localparam logic [4:0] FS_LSL = 5'b10100;

  localparam logic [2:0] DS_ALU = 3'b000;
  localparam logic [2:0] DS_RAM = 3'b001;
  localparam logic [2:0] DS_IR  = 3'b011;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;

  typedef struct packed {
    logic        as_sel;
    logic [2:0]  ds;
    logic [1:0]  ps;
    logic        pc_sel;
    logic        k_sel;
    logic        il;
    logic        sl;
    logic [4:0]  fs;
    logic        c0;
    logic        mw;
    logic        rw;
    logic [4:0]  da;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [63:0] k;
    logic [63:0] cu;
    logic        halted;
  } ctrl_t;

  function automatic logic [4:0] alu_fs(input op_e op);
    logic [4:0] fs;
    case (op)
      OP_SUB, OP_SUBS, OP_SUBI: fs = FS_SUB;
      OP_AND, OP_ANDI:          fs = FS_AND;
      OP_ORR, OP_ORRI:          fs = FS_ORR;
      OP_EOR, OP_EORI:          fs = FS_EOR;
      OP_LSL:                   fs = FS_LSL;
      OP_LSR:                   fs = FS_LSR;
      default:                  fs = FS_ADD;
    endcase
    return fs;
  endfunction

  // PC already points at instruction + 4 during EXEC, hence the -4.
  function automatic logic [63:0] br_offset(input logic [63:0] simm);
    return (simm << 2) - 64'd4;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates a B.cond condition code against the latched {V,C,N,Z} flags.
module branch_cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       taken_o
);

  logic z, n, c, v;

  assign z = nzcv_i[0];
  assign n = nzcv_i[1];
  assign c = nzcv_i[2];
  assign v = nzcv_i[3];

  always_comb begin
    taken_o = 1'b1;
    case (cond_i)
      COND_EQ: taken_o = z;
      COND_NE: taken_o = !z;
      COND_HS: taken_o = c;
      COND_LO: taken_o = !c;
      COND_MI: taken_o = n;
      COND_PL: taken_o = !n;
      COND_VS: taken_o = v;
      COND_VC: taken_o = !v;
      COND_HI: taken_o = c && !z;
      COND_LS: taken_o = !(c && !z);
      COND_GE: taken_o = (n == v);
      COND_LT: taken_o = (n != v);
      COND_GT: taken_o = !z && (n == v);
      COND_LE: taken_o = !(!z && (n == v));
      default: taken_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit for the single-bus LEGv8 datapath: sequences
// fetch/exec/mem, decodes the instruction register and holds NZCV.
//
// state    | meaning
// ST_FETCH | load IR from ROM, PC += 4
// ST_EXEC  | execute decoded instruction (address phase for LDUR)
// ST_MEM   | LDUR write-back from RAM
// ST_HALT  | unrecognised opcode seen; idle until reset
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IR_Out,
  input  logic [3:0]  SF,
  output logic        AS,
  output logic [2:0]  DS,
  output logic [1:0]  PS,
  output logic        PC_Sel,
  output logic        K_Sel,
  output logic        IL,
  output logic        SL,
  output logic [4:0]  FS,
  output logic        C0,
  output logic        MW,
  output logic        RW,
  output logic [4:0]  DA,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic [63:0] K,
  output logic [63:0] CU,
  output logic        halted
);

  state_e      state, state_d;
  logic [3:0]  nzcv, nzcv_d;
  op_e         op;
  ctrl_t       ctrl, ctrl_out;
  logic        bcond_taken;
  logic [4:0]  rd, rn, rm;
  logic [63:0] k_shamt, k_imm12, k_addr9, cu_b, cu_cb;

  assign rd      = IR_Out[4:0];
  assign rn      = IR_Out[9:5];
  assign rm      = IR_Out[20:16];
  assign k_shamt = {58'd0, IR_Out[15:10]};
  assign k_imm12 = {52'd0, IR_Out[21:10]};
  assign k_addr9 = {{55{IR_Out[20]}}, IR_Out[20:12]};
  assign cu_b    = br_offset({{38{IR_Out[25]}}, IR_Out[25:0]});
  assign cu_cb   = br_offset({{45{IR_Out[23]}}, IR_Out[23:5]});

  branch_cond_eval u_branch_cond_eval (
    .cond_i  (IR_Out[3:0]),
    .nzcv_i  (nzcv),
    .taken_o (bcond_taken)
  );

  always_comb begin
    op = OP_BAD;
    case (IR_Out[31:21])
      OPC_ADD:  op = OP_ADD;
      OPC_SUB:  op = OP_SUB;
      OPC_AND:  op = OP_AND;
      OPC_ORR:  op = OP_ORR;
      OPC_EOR:  op = OP_EOR;
      OPC_ADDS: op = OP_ADDS;
      OPC_SUBS: op = OP_SUBS;
      OPC_LSL:  op = OP_LSL;
      OPC_LSR:  op = OP_LSR;
      OPC_STUR: op = OP_STUR;
      OPC_LDUR: op = OP_LDUR;
      default:  ;
    endcase
    case (IR_Out[31:22])
      OPC_ADDI: op = OP_ADDI;
      OPC_SUBI: op = OP_SUBI;
      OPC_ANDI: op = OP_ANDI;
      OPC_ORRI: op = OP_ORRI;
      OPC_EORI: op = OP_EORI;
      default:  ;
    endcase
    case (IR_Out[31:24])
      OPC_CBZ:   op = OP_CBZ;
      OPC_CBNZ:  op = OP_CBNZ;
      OPC_BCOND: op = OP_BCOND;
      default:   ;
    endcase
    if (IR_Out[31:26] == OPC_B) op = OP_B;
  end

  always_comb begin
    ctrl    = '0;
    state_d = state;
    case (state)
      ST_FETCH: begin
        ctrl.il     = 1'b1;
        ctrl.as_sel = 1'b1;
        ctrl.ds     = DS_IR;
        ctrl.ps     = PS_INC;
        state_d     = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_ADDS, OP_SUBS, OP_LSL, OP_LSR: begin
            ctrl.sa = rn;
            ctrl.sb = rm;
            ctrl.da = rd;
            ctrl.rw = 1'b1;
            ctrl.fs = alu_fs(op);
            ctrl.c0 = (op == OP_SUB) || (op == OP_SUBS);
            ctrl.sl = (op == OP_ADDS) || (op == OP_SUBS);
            if (op == OP_LSL || op == OP_LSR) begin
              ctrl.k     = k_shamt;
              ctrl.k_sel = 1'b1;
            end
          end
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_EORI: begin
            ctrl.sa    = rn;
            ctrl.da    = rd;
            ctrl.rw    = 1'b1;
            ctrl.k     = k_imm12;
            ctrl.k_sel = 1'b1;
            ctrl.fs    = alu_fs(op);
            ctrl.c0    = (op == OP_SUBI);
          end
          OP_STUR: begin
            ctrl.sa    = rn;
            ctrl.sb    = rd;
            ctrl.k     = k_addr9;
            ctrl.k_sel = 1'b1;
            ctrl.fs    = FS_ADD;
            ctrl.mw    = 1'b1;
          end
          OP_LDUR: begin
            ctrl.sa    = rn;
            ctrl.k     = k_addr9;
            ctrl.k_sel = 1'b1;
            ctrl.fs    = FS_ADD;
            state_d    = ST_MEM;
          end
          OP_B: begin
            ctrl.cu = cu_b;
            ctrl.ps = PS_BR;
          end
          OP_CBZ, OP_CBNZ: begin
            ctrl.sa    = rd;
            ctrl.fs    = FS_ADD;
            ctrl.k_sel = 1'b1;
            ctrl.cu    = cu_cb;
            ctrl.ps    = ((op == OP_CBZ) == SF[0]) ? PS_BR : PS_HOLD;
          end
          OP_BCOND: begin
            ctrl.cu = cu_cb;
            ctrl.ps = bcond_taken ? PS_BR : PS_HOLD;
          end
          default: state_d = ST_HALT;
        endcase
      end
      ST_MEM: begin
        ctrl.sa    = rn;
        ctrl.k     = k_addr9;
        ctrl.k_sel = 1'b1;
        ctrl.fs    = FS_ADD;
        ctrl.ds    = DS_RAM;
        ctrl.da    = rd;
        ctrl.rw    = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_HALT: ctrl.halted = 1'b1;
      default: state_d = ST_FETCH;
    endcase
  end

  assign nzcv_d   = (state == ST_EXEC && ctrl.sl) ? SF : nzcv;
  // Reset masks every enable so no partial write escapes mid-instruction.
  assign ctrl_out = rst ? '0 : ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      nzcv  <= 4'd0;
    end else begin
      state <= state_d;
      nzcv  <= nzcv_d;
    end
  end

  assign AS     = ctrl_out.as_sel;
  assign DS     = ctrl_out.ds;
  assign PS     = ctrl_out.ps;
  assign PC_Sel = ctrl_out.pc_sel;
  assign K_Sel  = ctrl_out.k_sel;
  assign IL     = ctrl_out.il;
  assign SL     = ctrl_out.sl;
  assign FS     = ctrl_out.fs;
  assign C0     = ctrl_out.c0;
  assign MW     = ctrl_out.mw;
  assign RW     = ctrl_out.rw;
  assign DA     = ctrl_out.da;
  assign SA     = ctrl_out.sa;
  assign SB     = ctrl_out.sb;
  assign K      = ctrl_out.k;
  assign CU     = ctrl_out.cu;
  assign halted = ctrl_out.halted;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: an assembler plus reference model of
// the expected control word per cycle, driven by directed and random programs.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] IR_Out = 32'd0;
  logic [3:0]  SF = 4'd0;
  logic        AS, PC_Sel, K_Sel, IL, SL, C0, MW, RW, halted;
  logic [2:0]  DS;
  logic [1:0]  PS;
  logic [4:0]  FS, DA, SA, SB;
  logic [63:0] K, CU;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .rst(rst), .IR_Out(IR_Out), .SF(SF),
    .AS(AS), .DS(DS), .PS(PS), .PC_Sel(PC_Sel), .K_Sel(K_Sel), .IL(IL),
    .SL(SL), .FS(FS), .C0(C0), .MW(MW), .RW(RW), .DA(DA), .SA(SA), .SB(SB),
    .K(K), .CU(CU), .halted(halted)
  );

  typedef enum {
    I_ADD, I_SUB, I_AND, I_ORR, I_EOR, I_ADDS, I_SUBS, I_LSL, I_LSR,
    I_ADDI, I_SUBI, I_ANDI, I_ORRI, I_EORI,
    I_LDUR, I_STUR, I_B, I_CBZ, I_CBNZ, I_BCOND, I_BAD
  } kind_e;

  typedef struct {
    kind_e       kind;
    logic [4:0]  rd, rn, rm;
    logic [5:0]  shamt;
    logic [31:0] imm;
    logic [3:0]  cond;
  } instr_t;

  typedef struct packed {
    logic        asel;
    logic [2:0]  ds;
    logic [1:0]  ps;
    logic        pc_sel, k_sel, il, sl;
    logic [4:0]  fs;
    logic        c0, mw, rw;
    logic [4:0]  da, sa, sb;
    logic [63:0] k, cu;
    logic        halted;
  } cw_t;

  int checks = 0;
  int errors = 0;
  logic [3:0] nzcv_m = 4'd0;

  function automatic instr_t mk(kind_e kd, logic [4:0] rd, logic [4:0] rn, logic [4:0] rm,
                                logic [5:0] sh, logic [31:0] imm, logic [3:0] cond);
    instr_t i;
    i.kind = kd; i.rd = rd; i.rn = rn; i.rm = rm; i.shamt = sh; i.imm = imm; i.cond = cond;
    return i;
  endfunction

  function automatic logic [31:0] enc(instr_t i);
    logic [31:0] w;
    case (i.kind)
      I_ADD:   w = {11'b10001011000, i.rm, i.shamt, i.rn, i.rd};
      I_SUB:   w = {11'b11001011000, i.rm, i.shamt, i.rn, i.rd};
      I_AND:   w = {11'b10001010000, i.rm, i.shamt, i.rn, i.rd};
      I_ORR:   w = {11'b10101010000, i.rm, i.shamt, i.rn, i.rd};
      I_EOR:   w = {11'b11001010000, i.rm, i.shamt, i.rn, i.rd};
      I_ADDS:  w = {11'b10101011000, i.rm, i.shamt, i.rn, i.rd};
      I_SUBS:  w = {11'b11101011000, i.rm, i.shamt, i.rn, i.rd};
      I_LSL:   w = {11'b11010011011, i.rm, i.shamt, i.rn, i.rd};
      I_LSR:   w = {11'b11010011010, i.rm, i.shamt, i.rn, i.rd};
      I_ADDI:  w = {10'b1001000100, i.imm[11:0], i.rn, i.rd};
      I_SUBI:  w = {10'b1101000100, i.imm[11:0], i.rn, i.rd};
      I_ANDI:  w = {10'b1001001000, i.imm[11:0], i.rn, i.rd};
      I_ORRI:  w = {10'b1011001000, i.imm[11:0], i.rn, i.rd};
      I_EORI:  w = {10'b1101001000, i.imm[11:0], i.rn, i.rd};
      I_STUR:  w = {11'b11111000000, i.imm[8:0], 2'b00, i.rn, i.rd};
      I_LDUR:  w = {11'b11111000010, i.imm[8:0], 2'b00, i.rn, i.rd};
      I_B:     w = {6'b000101, i.imm[25:0]};
      I_CBZ:   w = {8'b10110100, i.imm[18:0], i.rd};
      I_CBNZ:  w = {8'b10110101, i.imm[18:0], i.rd};
      I_BCOND: w = {8'b01010100, i.imm[18:0], 1'b0, i.cond};
      default: w = i.imm[0] ? 32'hFFFF_FFFF : 32'h0000_0000;
    endcase
    return w;
  endfunction

  function automatic bit cond_holds(logic [3:0] cond, logic [3:0] f);
    bit z, n, c, v, r;
    z = f[0]; n = f[1]; c = f[2]; v = f[3];
    case (cond)
      4'd0:  r = z;
      4'd1:  r = !z;
      4'd2:  r = c;
      4'd3:  r = !c;
      4'd4:  r = n;
      4'd5:  r = !n;
      4'd6:  r = v;
      4'd7:  r = !v;
      4'd8:  r = c && !z;
      4'd9:  r = !c || z;
      4'd10: r = n == v;
      4'd11: r = n != v;
      4'd12: r = !z && n == v;
      4'd13: r = z || n != v;
      default: r = 1;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] offs(longint words);
    longint o;
    o = words * 4 - 4;
    return o;
  endfunction

  function automatic longint sx(logic [31:0] v, int bits);
    longint r;
    r = longint'(v) & ((longint'(1) << bits) - 1);
    if (v[bits-1]) r = r - (longint'(1) << bits);
    return r;
  endfunction

  function automatic cw_t exp_fetch();
    cw_t e = '0;
    e.il = 1; e.asel = 1; e.ds = 3'b011; e.ps = 2'b01;
    return e;
  endfunction

  function automatic cw_t exp_exec(instr_t i, logic [3:0] sf, logic [3:0] nz);
    cw_t e = '0;
    if (i.kind inside {I_ADD, I_SUB, I_AND, I_ORR, I_EOR, I_ADDS, I_SUBS, I_LSL, I_LSR}) begin
      e.sa = i.rn; e.sb = i.rm; e.da = i.rd; e.rw = 1;
    end
    if (i.kind inside {I_ADDI, I_SUBI, I_ANDI, I_ORRI, I_EORI}) begin
      e.sa = i.rn; e.da = i.rd; e.rw = 1; e.k_sel = 1; e.k = {52'd0, i.imm[11:0]};
    end
    case (i.kind)
      I_ADD, I_ADDI:  e.fs = 5'b01000;
      I_ADDS:         begin e.fs = 5'b01000; e.sl = 1; end
      I_SUB, I_SUBI:  begin e.fs = 5'b01001; e.c0 = 1; end
      I_SUBS:         begin e.fs = 5'b01001; e.c0 = 1; e.sl = 1; end
      I_AND, I_ANDI:  e.fs = 5'b00000;
      I_ORR, I_ORRI:  e.fs = 5'b00100;
      I_EOR, I_EORI:  e.fs = 5'b01100;
      I_LSL:          begin e.fs = 5'b10100; e.k = 64'(i.shamt); e.k_sel = 1; end
      I_LSR:          begin e.fs = 5'b10000; e.k = 64'(i.shamt); e.k_sel = 1; end
      I_STUR:         begin e.fs = 5'b01000; e.k_sel = 1; e.k = sx(i.imm, 9);
                            e.sa = i.rn; e.sb = i.rd; e.mw = 1; end
      I_LDUR:         begin e.fs = 5'b01000; e.k_sel = 1; e.k = sx(i.imm, 9); e.sa = i.rn; end
      I_B:            begin e.cu = offs(sx(i.imm, 26)); e.ps = 2'b10; end
      I_CBZ, I_CBNZ:  begin
        e.sa = i.rd; e.fs = 5'b01000; e.k_sel = 1; e.cu = offs(sx(i.imm, 19));
        e.ps = ((i.kind == I_CBZ && sf[0]) || (i.kind == I_CBNZ && !sf[0])) ? 2'b10 : 2'b00;
      end
      I_BCOND:        begin
        e.cu = offs(sx(i.imm, 19));
        e.ps = cond_holds(i.cond, nz) ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic cw_t exp_mem(instr_t i);
    cw_t e = '0;
    e.fs = 5'b01000; e.k_sel = 1; e.k = sx(i.imm, 9); e.sa = i.rn;
    e.ds = 3'b001; e.da = i.rd; e.rw = 1;
    return e;
  endfunction

  function automatic cw_t exp_halt();
    cw_t e = '0;
    e.halted = 1;
    return e;
  endfunction

  function automatic cw_t observed();
    cw_t o;
    o.asel = AS; o.ds = DS; o.ps = PS; o.pc_sel = PC_Sel; o.k_sel = K_Sel; o.il = IL;
    o.sl = SL; o.fs = FS; o.c0 = C0; o.mw = MW; o.rw = RW; o.da = DA; o.sa = SA;
    o.sb = SB; o.k = K; o.cu = CU; o.halted = halted;
    return o;
  endfunction

  task automatic check_cw(string tag, cw_t exp);
    cw_t obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; IR_Out = $urandom; SF = 4'($urandom);
    #1 check_cw("reset_c1", '0);
    @(negedge clk);
    IR_Out = $urandom;
    #1 check_cw("reset_c2", '0);
    @(negedge clk);
    rst = 0;
    nzcv_m = 4'd0;
  endtask

  // Entered at a negedge with the DUT in FETCH; returns the same way.
  task automatic run(instr_t i, logic [3:0] sf);
    IR_Out = $urandom; SF = 4'($urandom);
    #1 check_cw("fetch", exp_fetch());
    @(negedge clk);
    IR_Out = enc(i); SF = sf;
    #1 check_cw($sformatf("exec_%s", i.kind.name()), exp_exec(i, sf, nzcv_m));
    if (i.kind inside {I_ADDS, I_SUBS}) nzcv_m = sf;
    if (i.kind == I_LDUR) begin
      @(negedge clk);
      SF = 4'($urandom);
      #1 check_cw("ldur_mem", exp_mem(i));
    end
    if (i.kind == I_BAD) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        IR_Out = $urandom; SF = 4'($urandom);
        #1 check_cw("halt", exp_halt());
      end
      do_reset();
    end else begin
      @(negedge clk);
    end
  endtask

  initial begin
    instr_t ins;
    do_reset();

    run(mk(I_ADDI, 5'd2, 5'd31, 5'd0, 6'd0, 32'd7, 4'd0), 4'd0);
    run(mk(I_SUBS, 5'd1, 5'd2, 5'd3, 6'd0, 32'd0, 4'd0), 4'b0001);
    run(mk(I_BCOND, 5'd0, 5'd0, 5'd0, 6'd0, 32'd3, 4'h0), 4'd0);
    run(mk(I_BCOND, 5'd0, 5'd0, 5'd0, 6'd0, 32'd3, 4'h1), 4'd0);
    run(mk(I_LDUR, 5'd4, 5'd5, 5'd0, 6'd0, 32'hFFFF_FFF8, 4'd0), 4'd0);
    run(mk(I_CBZ, 5'd7, 5'd0, 5'd0, 6'd0, 32'hFFFF_FFFE, 4'd0), 4'b0000);
    run(mk(I_CBZ, 5'd7, 5'd0, 5'd0, 6'd0, 32'hFFFF_FFFE, 4'b0001), 4'b0001);
    run(mk(I_LSL, 5'd9, 5'd10, 5'd11, 6'd63, 32'd0, 4'd0), 4'd0);
    run(mk(I_STUR, 5'd3, 5'd6, 5'd0, 6'd0, 32'd255, 4'd0), 4'd0);
    run(mk(I_B, 5'd0, 5'd0, 5'd0, 6'd0, 32'h0200_0000, 4'd0), 4'd0);
    run(mk(I_BAD, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0, 4'd0), 4'd0);

    // Reset during LDUR's MEM cycle: no write-back, flags cleared.
    run(mk(I_ADDS, 5'd1, 5'd1, 5'd1, 6'd0, 32'd0, 4'd0), 4'b0001);
    ins = mk(I_LDUR, 5'd8, 5'd9, 5'd0, 6'd0, 32'd16, 4'd0);
    IR_Out = $urandom;
    #1 check_cw("fetch", exp_fetch());
    @(negedge clk);
    IR_Out = enc(ins);
    #1 check_cw("exec_ldur_pre_rst", exp_exec(ins, SF, nzcv_m));
    @(negedge clk);
    rst = 1;
    #1 check_cw("rst_in_mem", '0);
    @(negedge clk);
    rst = 0;
    nzcv_m = 4'd0;
    run(mk(I_BCOND, 5'd0, 5'd0, 5'd0, 6'd0, 32'd5, 4'h0), 4'd0);

    for (int n = 0; n < 400; n++) begin
      kind_e kd;
      kd = kind_e'($urandom_range(0, 20));
      if (kd == I_BAD && $urandom_range(0, 3) != 0) kd = I_SUBS;
      ins = mk(kd, 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
               $urandom, 4'($urandom));
      run(ins, 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle control unit for the single-bus LEGv8 CPU. It sits directly upstream of `datapath_core`. It consumes the fetched instruction (`IR_Out`) and the live ALU flags (`SF`). It generates the full control word that `datapath_core` accepts: `AS, DS, PS, PC_Sel, K_Sel, IL, SL, FS, C0, MW, RW, DA, SA, SB, K, CU`. It sequences fetch, execute and memory cycles, and it holds the architectural NZCV status register used by conditional branches.

## Interface
Parameters:
- None. All encodings are fixed constants in `cpu_ctrl_pkg`.

Ports (clock and reset first):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `IR_Out`  in  32  instruction register contents from `datapath_core`.
- `SF`  in  4  live ALU flags for the current cycle: `{V,C,N,Z}` = `SF[3:0]`.
- `AS`  out  1  memory address source: 1 = PC, 0 = ALU result.
- `DS`  out  3  register-file data source: 000 = ALU, 001 = RAM, 011 = ROM/IR path.
- `PS`  out  2  PC operation: 00 = hold, 01 = PC+4, 10 = PC+CU.
- `PC_Sel`  out  1  PC load source; always 0 (CU offset) in this instruction subset.
- `K_Sel`  out  1  ALU B operand: 1 = K, 0 = register SB.
- `IL`, `SL`, `MW`, `RW`  out  1 each  IR load, status load, memory write, register write.
- `FS`  out  5  ALU function.
- `C0`  out  1  ALU carry-in.
- `DA`, `SA`, `SB`  out  5 each  register addresses (destination, A, B).
- `K`  out  64  ALU constant.
- `CU`  out  64  PC branch offset.
- `halted`  out  1  high after an unrecognised opcode.

## Operation
States and transitions (the state register is `state`):
- FETCH → EXEC.
- EXEC → MEM for LDUR; → HALT for an unrecognised opcode; otherwise → FETCH.
- MEM → FETCH.
- HALT stays in HALT until `rst`.

Output rules:
- Outputs are combinational from `state`, `IR_Out`, `SF` and the internal `nzcv` register.
- Every output not listed for a state drives 0.

FETCH:
- Drives `IL=1`, `AS=1`, `DS=011`, `PS=01`.
- The PC therefore equals instruction address + 4 during EXEC.

R-type (`SA`=Rn `[9:5]`, `SB`=Rm `[20:16]`, `DA`=Rd `[4:0]`, `K_Sel=0`, `RW=1`):
- ADD: FS=01000.
- SUB: FS=01001, C0=1.
- AND: FS=00000.
- ORR: FS=00100.
- EOR: FS=01100.
- ADDS / SUBS: as ADD / SUB, plus `SL=1`.
- LSL: FS=10100, K=shamt `[15:10]`, K_Sel=1.
- LSR: FS=10000, K=shamt `[15:10]`, K_Sel=1.

I-type (opcode `[31:22]`):
- ADDI, SUBI, ANDI, ORRI, EORI.
- `K` = zero-extended imm12 `[21:10]`, `K_Sel=1`, `RW=1`.
- FS and C0 as for the matching R-type instruction.

D-type (`K` = sign-extended addr9 `[20:12]`, FS=ADD, `K_Sel=1`, `SA`=Rn):
- STUR: EXEC only; `SB`=Rt, `MW=1`.
- LDUR EXEC: address phase, `RW=0`.
- LDUR MEM: same address controls, plus `DS=001`, `DA`=Rt, `RW=1`.

Branches (all offsets computed mod 2^64):
- B: `CU` = (sext(imm26)<<2) − 4, `PS=10`.
- CBZ / CBNZ:
  - `SA`=Rt, FS=ADD, `K_Sel=1`, K=0.
  - Taken when `SF[0]`=1 (CBZ) or `SF[0]`=0 (CBNZ).
  - Offset imm19 `[23:5]`, same CU formula as B.
  - Not taken: `PS=00`.
- B.cond:
  - Evaluates cond `[3:0]` against the internal `nzcv` register.
  - Codes: EQ, NE, HS, LO, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE; E and F mean always.
  - Offset from imm19 as above.

NZCV register:
- Loads `SF` at the end of EXEC when `SL=1`.
- Reset value 0.

Unrecognised opcode:
- EXEC drives all enables 0 and moves to HALT.
- HALT drives all outputs 0 and `halted=1`.

## Timing
- Synchronous reset: while `rst`=1, outputs are forced to 0 and `state`, `nzcv` and `halted` clear on the edge.
- The first cycle after `rst` falls is FETCH (`IL=1`).
- `rst` asserted in any state, including mid-LDUR or HALT, returns to FETCH next cycle; no partial writes occur.
- Cycles per instruction: 2 for ALU, STUR and branch instructions; 3 for LDUR.
- Flags: CBZ/CBNZ use same-cycle `SF`. B.cond uses `nzcv` latched by an earlier instruction, including one immediately preceding.
- No output depends on `clk` except through `state`.

## Structure
- `cpu_ctrl_pkg` holds:
  - state enum;
  - opcode constants (R, I, D, B, CB, B.cond);
  - FS codes;
  - DS and PS codes;
  - condition codes.
- Sub-module `branch_cond_eval`: combinational, `cond` + `nzcv` → `taken`.

## Test plan
- Reset: `rst`=1 for 2 cycles → all outputs 0; first cycle after release has `IL=1`, `PS=01`, `DS=011`, `AS=1`.
- ADDI X2,X31,#7 (`IR_Out`=0x91001FE2) → EXEC drives FS=01000, K_Sel=1, K=7, SA=31, DA=2, RW=1, PS=00; the next cycle is FETCH.
- SUBS X1,X2,X3 with `SF`=0001 → SL=1 and `nzcv` latches 0001. A following B.EQ with imm19=3 → PS=10, CU=8. B.NE with the same imm19 → PS=00.
- LDUR X4,[X5,#-8] → EXEC: K=0xFFFF_FFFF_FFFF_FFF8, RW=0. MEM: DS=001, DA=4, RW=1. Then FETCH.
- CBZ X7,#-2 → with `SF[0]`=0: PS=00. With `SF[0]`=1: PS=10, CU=0xFFFF_FFFF_FFFF_FFF4.
- `IR_Out`=0x00000000 → HALT and `halted`=1; IL stays 0 for 5 cycles. Asserting `rst` → FETCH.
